// File: rtl/ex_muldiv_hilo_if.sv
// ID/EX-side bundle for the iterative multiply/divide unit and its HI/LO outputs.
// The master drives operands and control; the slave is ex_muldiv_hilo.
interface ex_muldiv_hilo_if #(
  parameter int WIDTH = 32
);
  logic             Start_In;
  logic [3:0]       Op_In;
  logic [WIDTH-1:0] A_In;
  logic [WIDTH-1:0] B_In;
  logic             Flush_In;
  logic [WIDTH-1:0] HI_Out;
  logic [WIDTH-1:0] LO_Out;
  logic             Busy_Out;
  logic             Done_Out;
  logic             Stall_Out;

  modport master (
    output Start_In, Op_In, A_In, B_In, Flush_In,
    input  HI_Out, LO_Out, Busy_Out, Done_Out, Stall_Out
  );

  modport slave (
    input  Start_In, Op_In, A_In, B_In, Flush_In,
    output HI_Out, LO_Out, Busy_Out, Done_Out, Stall_Out
  );
endinterface

// File: rtl/ex_muldiv_hilo.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU (+ MADD/MSUB when MULDIV_ACC_EN is defined)
// with architectural HI/LO; one iteration per clock, sign fix-up in a final FIX cycle.
module ex_muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input logic            Clk,
  input logic            Rst_n,
  ex_muldiv_hilo_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MADD  = 4'd5;
  localparam logic [3:0] OP_MSUB  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  logic [1:0]         state_q,   state_d;
  logic [CW-1:0]      cnt_q,     cnt_d;
  logic [3:0]         op_q,      op_d;
  logic [WIDTH-1:0]   a_q,       a_d;
  logic [WIDTH-1:0]   mag_a_q,   mag_a_d;
  logic [WIDTH-1:0]   mag_b_q,   mag_b_d;
  logic               neg_a_q,   neg_a_d;
  logic               neg_b_q,   neg_b_d;
  logic [2*WIDTH-1:0] res_q,     res_d;
  logic [WIDTH-1:0]   hi_q,      hi_d;
  logic [WIDTH-1:0]   lo_q,      lo_d;
  logic               done_q,    done_d;

  logic               in_long, in_div, in_signed;
  logic [WIDTH:0]     rem_sh, rem_sub;
  logic               rem_ge;
  logic [2*WIDTH-1:0] prod, hilo;
  logic [WIDTH-1:0]   quo, rem;

  // Op 5/6 only count as long ops when the accumulate path is built in.
  always_comb begin
    in_long = (bus.Op_In >= OP_MULT) && (bus.Op_In <= OP_DIVU);
`ifdef MULDIV_ACC_EN
    in_long = in_long || (bus.Op_In == OP_MADD) || (bus.Op_In == OP_MSUB);
`endif
    in_div    = (bus.Op_In == OP_DIV) || (bus.Op_In == OP_DIVU);
    in_signed = (bus.Op_In == OP_MULT) || (bus.Op_In == OP_DIV) ||
                (bus.Op_In == OP_MADD) || (bus.Op_In == OP_MSUB);
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    mag_a_d = mag_a_q;
    mag_b_d = mag_b_q;
    neg_a_d = neg_a_q;
    neg_b_d = neg_b_q;
    res_d   = res_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    rem_sh  = '0;
    rem_sub = '0;
    rem_ge  = 1'b0;
    prod    = '0;
    hilo    = '0;
    quo     = '0;
    rem     = '0;

    case (state_q)
      S_IDLE: begin
        if (bus.Start_In) begin
          if (bus.Op_In == OP_MTHI) begin
            hi_d = bus.A_In;
          end else if (bus.Op_In == OP_MTLO) begin
            lo_d = bus.A_In;
          end else if (in_long) begin
            state_d = in_div ? S_DIV : S_MUL;
            cnt_d   = CNT_MAX;
            op_d    = bus.Op_In;
            a_d     = bus.A_In;
            neg_a_d = in_signed & bus.A_In[WIDTH-1];
            neg_b_d = in_signed & bus.B_In[WIDTH-1];
            mag_a_d = neg_a_d ? -bus.A_In : bus.A_In;
            mag_b_d = neg_b_d ? -bus.B_In : bus.B_In;
            res_d   = '0;
          end
        end
      end
      S_MUL: begin
        // MSB-first shift-add: double the partial product, add A when this B bit is set.
        res_d = {res_q[2*WIDTH-2:0], 1'b0} +
                (mag_b_q[cnt_q] ? {{WIDTH{1'b0}}, mag_a_q} : {2*WIDTH{1'b0}});
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_DIV: begin
        // Restoring step: remainder lives in the upper half, quotient bits shift into the lower.
        rem_sh  = {res_q[2*WIDTH-1:WIDTH], mag_a_q[cnt_q]};
        rem_ge  = rem_sh >= {1'b0, mag_b_q};
        rem_sub = rem_ge ? rem_sh - {1'b0, mag_b_q} : rem_sh;
        res_d   = {rem_sub[WIDTH-1:0], res_q[WIDTH-2:0], rem_ge};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        if ((op_q == OP_DIV) || (op_q == OP_DIVU)) begin
          quo = (neg_a_q ^ neg_b_q) ? -res_q[WIDTH-1:0] : res_q[WIDTH-1:0];
          rem = neg_a_q ? -res_q[2*WIDTH-1:WIDTH] : res_q[2*WIDTH-1:WIDTH];
          if (mag_b_q == '0) begin
            quo = '1;
            rem = a_q;
          end
          hilo = {rem, quo};
        end else begin
          prod = (neg_a_q ^ neg_b_q) ? -res_q : res_q;
          hilo = prod;
`ifdef MULDIV_ACC_EN
          if (op_q == OP_MADD)      hilo = {hi_q, lo_q} + prod;
          else if (op_q == OP_MSUB) hilo = {hi_q, lo_q} - prod;
`endif
        end
        hi_d    = hilo[2*WIDTH-1:WIDTH];
        lo_d    = hilo[WIDTH-1:0];
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    // Flush abandons an in-flight op without touching HI/LO; it has no meaning in IDLE.
    if (bus.Flush_In && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
    end
  end

  // NOTE: every flop, including the iteration datapath, is cleared by the async reset so an
  // op killed mid-flight leaves no stale partial result; sequential state uses <= only.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      mag_a_q <= '0;
      mag_b_q <= '0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
      res_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      mag_a_q <= mag_a_d;
      mag_b_q <= mag_b_d;
      neg_a_q <= neg_a_d;
      neg_b_q <= neg_b_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.HI_Out    = hi_q;
  assign bus.LO_Out    = lo_q;
  assign bus.Busy_Out  = (state_q != S_IDLE);
  assign bus.Done_Out  = done_q;
  assign bus.Stall_Out = bus.Busy_Out | (bus.Start_In & in_long & (state_q == S_IDLE));
endmodule

// File: tb/tb_ex_muldiv_hilo.sv
// Self-checking bench for ex_muldiv_hilo: directed plan steps plus random ops against an
// arithmetic reference model of HI/LO; expectations follow MULDIV_ACC_EN when defined.
module tb_ex_muldiv_hilo;
  localparam int W = 32;

  logic Clk = 1'b0;
  logic Rst_n;
  int   errors = 0;
  int   checks = 0;
  logic [W-1:0] hi_m, lo_m;

  ex_muldiv_hilo_if #(.WIDTH(W)) bus ();
  ex_muldiv_hilo #(.WIDTH(W)) dut (.Clk(Clk), .Rst_n(Rst_n), .bus(bus));

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
      end
  endtask

  function automatic bit acc_built();
`ifdef MULDIV_ACC_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit is_long_op(input logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd4) || (acc_built() && (op == 4'd5 || op == 4'd6));
  endfunction

  // Reference: plain 64-bit and integer arithmetic straight from the op definitions.
  task automatic model_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [63:0] sp, up, acc;
    int sa, sb;
    sp  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    up  = {32'd0, a} * {32'd0, b};
    acc = {hi_m, lo_m};
    sa  = a;
    sb  = b;
    case (op)
      4'd1: {hi_m, lo_m} = sp;
      4'd2: {hi_m, lo_m} = up;
      4'd3: begin
        if (b == 0)                                   begin lo_m = '1; hi_m = a; end
        else if (a == 32'h8000_0000 && b == '1)       begin lo_m = 32'h8000_0000; hi_m = 0; end
        else                                          begin lo_m = sa / sb; hi_m = sa % sb; end
      end
      4'd4: begin
        if (b == 0) begin lo_m = '1; hi_m = a; end
        else        begin lo_m = a / b; hi_m = a % b; end
      end
      4'd5: if (acc_built()) {hi_m, lo_m} = acc + sp;
      4'd6: if (acc_built()) {hi_m, lo_m} = acc - sp;
      4'd7: hi_m = a;
      4'd8: lo_m = a;
      default: ;
    endcase
  endtask

  task automatic drive_idle();
    bus.Start_In = 1'b0;
    bus.Op_In    = 4'd0;
    bus.Flush_In = 1'b0;
  endtask

  // Single-cycle path: short ops and anything that must behave as a NOP.
  task automatic run_short(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b);
    @(negedge Clk);
    bus.Start_In = 1'b1; bus.Op_In = op; bus.A_In = a; bus.B_In = b;
    #1 check({tag, "_stall"}, 64'(bus.Stall_Out), 64'd0);
    @(posedge Clk);
    #1 drive_idle();
    model_op(op, a, b);
    check({tag, "_busy"}, 64'(bus.Busy_Out), 64'd0);
    check({tag, "_hilo"}, {bus.HI_Out, bus.LO_Out}, {hi_m, lo_m});
  endtask

  // Long op: accept, then watch a bounded window for Busy/Done timing and the result.
  task automatic run_long(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
    int busy_cnt, done_cnt, overlap;
    busy_cnt = 0; done_cnt = 0; overlap = 0;
    @(negedge Clk);
    bus.Start_In = 1'b1; bus.Op_In = op; bus.A_In = a; bus.B_In = b;
    #1 check({tag, "_stall"}, 64'(bus.Stall_Out), 64'd1);
    @(posedge Clk);
    #1 drive_idle();
    bus.A_In = $urandom; bus.B_In = $urandom;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge Clk);
      if (bus.Busy_Out) busy_cnt++;
      if (bus.Done_Out) begin
        done_cnt++;
        if (bus.Busy_Out) overlap++;
      end
    end
    model_op(op, a, b);
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(W + 1));
    check({tag, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({tag, "_done_busy_overlap"}, 64'(overlap), 64'd0);
    check({tag, "_hilo"}, {bus.HI_Out, bus.LO_Out}, {hi_m, lo_m});
  endtask

  initial begin
    logic [3:0] op;
    logic [W-1:0] a, b;
    int done_seen;

    drive_idle();
    bus.A_In = '0; bus.B_In = '0;
    hi_m = '0; lo_m = '0;
    Rst_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1 check("reset_hilo", {bus.HI_Out, bus.LO_Out}, 64'd0);
    check("reset_busy_done", {62'd0, bus.Busy_Out, bus.Done_Out}, 64'd0);
    @(negedge Clk) Rst_n = 1'b1;

    // Step 1: MTHI / MTLO
    run_short("mthi", 4'd7, 32'h1234_5678, 32'h0);
    check("mthi_hi_const", 64'(bus.HI_Out), 64'h1234_5678);
    run_short("mtlo", 4'd8, 32'hCAFE_F00D, 32'h0);
    check("mtlo_lo_const", 64'(bus.LO_Out), 64'hCAFE_F00D);

    // Step 2: MULT -3 * 7
    run_long("mult", 4'd1, 32'hFFFF_FFFD, 32'd7);
    check("mult_const", {bus.HI_Out, bus.LO_Out}, 64'hFFFF_FFFF_FFFF_FFEB);

    // Step 3: DIVU / DIV
    run_long("divu", 4'd4, 32'd100, 32'd7);
    check("divu_const", {bus.HI_Out, bus.LO_Out}, {32'd2, 32'd14});
    run_long("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2);
    check("div_neg_const", {bus.HI_Out, bus.LO_Out}, 64'hFFFF_FFFF_FFFF_FFFD);

    // Step 4: divide by zero and most-negative / -1
    run_long("div0", 4'd3, 32'h55, 32'd0);
    check("div0_const", {bus.HI_Out, bus.LO_Out}, {32'h55, 32'hFFFF_FFFF});
    run_long("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf_const", {bus.HI_Out, bus.LO_Out}, {32'h0, 32'h8000_0000});

    // Step 5: MULTU max*max, then accumulate from HI:LO = 0:5
    run_long("multu", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_const", {bus.HI_Out, bus.LO_Out}, 64'hFFFF_FFFE_0000_0001);
    run_short("pre_hi", 4'd7, 32'd0, 32'd0);
    run_short("pre_lo", 4'd8, 32'd5, 32'd0);
    if (acc_built()) begin
      run_long("madd", 4'd5, 32'd2, 32'd3);
      check("madd_const", {bus.HI_Out, bus.LO_Out}, 64'd11);
      run_long("msub", 4'd6, 32'd2, 32'd3);
      check("msub_const", {bus.HI_Out, bus.LO_Out}, 64'd5);
    end else begin
      run_short("madd_nop", 4'd5, 32'd2, 32'd3);
      run_short("msub_nop", 4'd6, 32'd2, 32'd3);
      check("acc_nop_const", {bus.HI_Out, bus.LO_Out}, 64'd5);
    end
    run_short("nop15", 4'd15, 32'hDEAD_BEEF, 32'h1);

    // Random long and short ops against the model
    for (int i = 0; i < 14; i++) begin
      op = 4'($urandom_range(1, acc_built() ? 8 : 6));
      a  = $urandom;
      b  = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
      if (is_long_op(op)) run_long("rand_long", op, a, b);
      else                run_short("rand_short", op, a, b);
    end

    // Step 6a: flush MULTU at cycle 10
    @(negedge Clk);
    bus.Start_In = 1'b1; bus.Op_In = 4'd2; bus.A_In = 32'h1234; bus.B_In = 32'h5678;
    @(posedge Clk);
    #1 drive_idle();
    repeat (10) @(negedge Clk);
    bus.Flush_In = 1'b1;
    @(posedge Clk);
    #1 bus.Flush_In = 1'b0;
    check("flush_busy", 64'(bus.Busy_Out), 64'd0);
    done_seen = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge Clk);
      if (bus.Done_Out) done_seen++;
    end
    check("flush_no_done", 64'(done_seen), 64'd0);
    check("flush_hilo", {bus.HI_Out, bus.LO_Out}, {hi_m, lo_m});

    // Flush together with Start in IDLE: the start is taken
    @(negedge Clk);
    bus.Start_In = 1'b1; bus.Flush_In = 1'b1; bus.Op_In = 4'd4; bus.A_In = 32'd9; bus.B_In = 32'd4;
    @(posedge Clk);
    #1 drive_idle();
    check("flush_start_busy", 64'(bus.Busy_Out), 64'd1);
    repeat (W + 2) @(negedge Clk);
    model_op(4'd4, 32'd9, 32'd4);
    check("flush_start_hilo", {bus.HI_Out, bus.LO_Out}, {hi_m, lo_m});

    // Step 6b: async reset mid-DIV, between edges
    run_short("pre_rst_hi", 4'd7, 32'hA5A5_A5A5, 32'd0);
    @(negedge Clk);
    bus.Start_In = 1'b1; bus.Op_In = 4'd3; bus.A_In = 32'd1000; bus.B_In = 32'd3;
    @(posedge Clk);
    #1 drive_idle();
    repeat (5) @(negedge Clk);
    #2 Rst_n = 1'b0;
    #1 check("rst_mid_hilo", {bus.HI_Out, bus.LO_Out}, 64'd0);
    check("rst_mid_busy_done", {62'd0, bus.Busy_Out, bus.Done_Out}, 64'd0);
    hi_m = '0; lo_m = '0;
    @(negedge Clk) Rst_n = 1'b1;
    run_long("post_rst_mult", 4'd1, 32'd6, 32'hFFFF_FFF9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ex_muldiv_hilo.md
Name: ex_muldiv_hilo

Overview:
- EX-stage iterative multiply/divide unit with the architectural HI/LO registers.
- Consumes operands and operation select from the ID/EX pipeline register outputs.
- Runs MULT/MULTU/DIV/DIVU/MADD/MSUB over multiple cycles and raises a stall to the hazard unit while busy.
- Performs MTHI/MTLO in a single cycle.

Parameters:
- WIDTH, 32, operand and HI/LO width; the iteration count equals WIDTH.

Ports:
- Clk  input  1  pipeline clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- Start_In  input  1  op valid from ID/EX this cycle.
- Op_In  input  4  0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MADD, 6 MSUB, 7 MTHI, 8 MTLO, 9-15 NOP.
- A_In  input  WIDTH  rs value (RegisterRead1).
- B_In  input  WIDTH  rt value (RegisterRead2).
- Flush_In  input  1  abort the in-flight op.
- HI_Out  output  WIDTH  HI register.
- LO_Out  output  WIDTH  LO register.
- Busy_Out  output  1  registered; high while state is not IDLE.
- Done_Out  output  1  one-cycle pulse when a long op commits.
- Stall_Out  output  1  combinational: Busy_Out | (Start_In & long-op & state==IDLE).

Behaviour:
- Interface: one clock (Clk); reset Rst_n is asynchronous, active-low.
- Reset (asynchronous, any time, including mid-operation):
  - State goes to IDLE.
  - HI_Out=0, LO_Out=0, Busy_Out=0, Done_Out=0.
  - All iteration registers are cleared.
- Long ops: 1-6. Short ops: 7-8.
- States:
  - IDLE: accept Start_In. A long op goes to MUL (1,2,5,6) or DIV (3,4). A short op stays in IDLE.
  - MUL / DIV: WIDTH iterations, one per clock. The counter runs from WIDTH-1 down to 0. At 0, go to FIX.
  - FIX: apply sign correction / accumulate, write HI/LO, go to IDLE. Done_Out is high in the following cycle.
- Latency:
  - Start accepted at edge E0.
  - Busy_Out is high for the WIDTH+1 cycles after E0.
  - HI/LO are updated at edge E(WIDTH+1).
  - Done_Out is high for exactly one cycle after that edge, coincident with Busy_Out low.
- MTHI/MTLO: HI or LO takes A_In at the accepting edge. No Busy, no Done, no stall.
- Operands are latched at acceptance; A_In/B_In changes afterwards are ignored.
- Multiply:
  - Shift-add on magnitudes.
  - Signed ops (MULT/MADD/MSUB) negate the 2*WIDTH product in FIX when the operand signs differ.
  - Result is {HI,LO}.
- MADD / MSUB:
  - {HI,LO} ± product, computed with 2*WIDTH wrap-around arithmetic.
  - The HI/LO values used are those at FIX time.
- Divide:
  - Restoring division on magnitudes; LO = quotient, HI = remainder.
  - Signed quotient truncates toward zero; the remainder takes the dividend's sign.
- Boundary cases:
  - Divide by zero, signed or unsigned: LO = all ones, HI = dividend (original A). Still takes the full latency.
  - Signed most-negative / -1: LO = 0x80000000, HI = 0.
  - Start_In while busy: ignored. The upstream stall guarantees this does not happen; no error is flagged.
  - Flush_In high in MUL/DIV/FIX: next state IDLE, HI/LO unchanged, no Done pulse. Flush_In in IDLE is ignored.
  - Flush_In and Start_In together in IDLE: Start_In wins. Flush only applies to an in-flight op.
  - Simultaneous short op and FIX cannot occur; short ops are accepted only in IDLE.
  - NOP codes and Start_In low: no state change.

Optional Feature:
- Macro: MULDIV_ACC_EN.
- Defined: MADD/MSUB accumulate as above.
- Undefined: Op 5/6 are treated as NOP. No busy, no stall, HI/LO unchanged, and the accumulate adder is not synthesized.

Test Plan:
1. MTHI with A=0x12345678, then MTLO with A=0xCAFEF00D -> HI=0x12345678, LO=0xCAFEF00D after each respective edge; Busy_Out and Stall_Out stay 0.
2. MULT A=0xFFFFFFFD (-3), B=7 -> Stall_Out high at accept; Busy_Out high 33 cycles; HI=0xFFFFFFFF, LO=0xFFFFFFEB; single Done_Out pulse.
3. DIVU A=100, B=7 -> LO=14, HI=2. Then DIV A=0xFFFFFFF9 (-7), B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
4. DIV A=0x55, B=0 -> LO=0xFFFFFFFF, HI=0x55 after full latency. Then DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
5. MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. With MULDIV_ACC_EN and HI:LO=0:5: MADD A=2, B=3 -> LO=11; then MSUB same operands -> LO=5. Without the macro -> HI:LO stays 0:5, Busy_Out 0.
6. Abort cases:
   - Start MULTU, assert Flush_In at cycle 10 -> Busy_Out low next cycle, HI/LO unchanged, no Done_Out.
   - Separately, pull Rst_n low mid-DIV between clock edges -> HI/LO/Busy/Done go to 0 immediately.
